// File: rtl/bus_unit_if.sv
// -----------------------------------------------------------------------------
// bus_unit_if
//
// External bus and timing-controller handshake bundle for bus_unit.
//
// Signals
//   oenb   : 9-bit control enables from the timing controller
//            bit0 ADDL, bit1 ADDH, bit2 DATA, bit3 REGR, bit4 REGW,
//            bit5 C_WR, bit6 D_WR, bit7 UPPC, bit8 PDAT
//   ale    : address latch enable from the timing controller
//   dbin   : data sampled from the AD pins
//   a_hi   : address bus A15..A8
//   ad_out : multiplexed AD7..AD0 drive value
//   ah_oe  : A15..A8 output enable
//   ad_oe  : AD7..AD0 output enable
//
// Modports
//   master : timing controller / pin side (drives controls and pin data)
//   slave  : bus_unit (drives the address/data pin values and enables)
// -----------------------------------------------------------------------------
interface bus_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);

  logic [8:0]               oenb;
  logic                     ale;
  logic [DATA_W-1:0]        dbin;
  logic [ADDR_W-DATA_W-1:0] a_hi;
  logic [DATA_W-1:0]        ad_out;
  logic                     ah_oe;
  logic                     ad_oe;

  modport master (
    output oenb,
    output ale,
    output dbin,
    input  a_hi,
    input  ad_out,
    input  ah_oe,
    input  ad_oe
  );

  modport slave (
    input  oenb,
    input  ale,
    input  dbin,
    output a_hi,
    output ad_out,
    output ah_oe,
    output ad_oe
  );

endinterface

// File: rtl/bus_unit.sv
// -----------------------------------------------------------------------------
// bus_unit
//
// Address/data bus unit of an 8085-style CPU. Holds the program counter, the
// instruction register and the two-byte temporary register {W,Z}, latches the
// address of each machine cycle and drives the multiplexed A/AD pins.
//
// Parameters
//   ADDR_W : address / PC width (default 16)
//   DATA_W : data bus width     (default 8)
//
// Ports
//   clk_    : clock, all state updates on the rising edge
//   rst_    : asynchronous, active-high reset
//   bus     : bus_unit_if.slave (oenb, ale, dbin in; a_hi, ad_out, ah_oe,
//             ad_oe out)
//   dadr    : data address from the register file (HL/SP/BC/DE/WZ)
//   wdat    : write data from the register file / ALU
//   pcld    : PC load request (jump/call/ret/rst)
//   pcval   : PC load value
//   pc      : program counter
//   ireg    : instruction register
//   treg    : temporary register {W,Z}
//   tful    : both treg bytes loaded since the last opcode fetch
//   cur_adr : address of the current machine cycle
//   err     : sticky protocol error (C_WR and D_WR in the same cycle)
// -----------------------------------------------------------------------------
module bus_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk_,
  input  logic              rst_,
  bus_unit_if.slave         bus,
  input  logic [ADDR_W-1:0] dadr,
  input  logic [DATA_W-1:0] wdat,
  input  logic              pcld,
  input  logic [ADDR_W-1:0] pcval,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ireg,
  output logic [ADDR_W-1:0] treg,
  output logic              tful,
  output logic [ADDR_W-1:0] cur_adr,
  output logic              err
);

  // Bit positions inside oenb
  localparam int EN_ADDL = 0;
  localparam int EN_ADDH = 1;
  localparam int EN_DATA = 2;
  localparam int EN_REGR = 3;
  localparam int EN_REGW = 4;
  localparam int EN_C_WR = 5;
  localparam int EN_D_WR = 6;
  localparam int EN_UPPC = 7;
  localparam int EN_PDAT = 8;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Which half of {W,Z} the next operand byte lands in
  typedef enum logic {
    PTR_Z = 1'b0,
    PTR_W = 1'b1
  } byte_ptr_e;

  byte_ptr_e byte_ptr;

  logic [ADDR_W-1:0] src;
  logic              fetch_load;
  logic              data_load;
  logic              wr_collide;
  logic              unused_regr_regw;

  // REGR/REGW belong to the register file; they pass through this block
  // untouched.
  assign unused_regr_regw = bus.oenb[EN_REGR] ^ bus.oenb[EN_REGW];

  // The address presented in a machine cycle comes either from the register
  // file (PDAT) or from the program counter.
  assign src = bus.oenb[EN_PDAT] ? dadr : pc;

  // An opcode byte is captured on C_WR; an operand byte on D_WR. Both are
  // suppressed during write cycles (DATA=1) because the AD pins carry our own
  // write data then. C_WR wins over D_WR so a collision still fetches.
  assign fetch_load = bus.oenb[EN_C_WR] & ~bus.oenb[EN_DATA];
  assign data_load  = bus.oenb[EN_D_WR] & ~bus.oenb[EN_C_WR] & ~bus.oenb[EN_DATA];
  assign wr_collide = bus.oenb[EN_C_WR] & bus.oenb[EN_D_WR];

  // Pin drive: during ALE the source address is passed straight through so
  // the external latch sees it in the same cycle; afterwards the latched
  // cycle address (or write data on AD) is held.
  always_comb begin
    bus.a_hi   = cur_adr[ADDR_W-1:DATA_W];
    bus.ad_out = cur_adr[DATA_W-1:0];
    if (bus.ale) begin
      bus.a_hi   = src[ADDR_W-1:DATA_W];
      bus.ad_out = src[DATA_W-1:0];
    end else if (bus.oenb[EN_DATA]) begin
      bus.ad_out = wdat;
    end
  end

  // Output enables are pure pass-through of the controller enables so the
  // pins turn around without extra latency.
  assign bus.ah_oe = bus.oenb[EN_ADDH];
  assign bus.ad_oe = bus.oenb[EN_ADDL] | bus.oenb[EN_DATA];

  // Cycle address latch and program counter. A PC load (jump/call/ret/rst)
  // overrides a simultaneous increment; the increment wraps naturally.
  always_ff @(posedge clk_ or posedge rst_) begin
    if (rst_) begin
      cur_adr <= '0;
      pc      <= '0;
    end else begin
      if (bus.ale) begin
        cur_adr <= src;
      end
      if (pcld) begin
        pc <= pcval;
      end else if (bus.oenb[EN_UPPC]) begin
        pc <= pc + PC_ONE;
      end
    end
  end

  // Instruction and operand capture. An opcode fetch restarts the operand
  // sequence, so the next operand byte always lands in Z. Operand bytes then
  // alternate Z, W, Z, ... and tful stays set once both halves were written.
  always_ff @(posedge clk_ or posedge rst_) begin
    if (rst_) begin
      ireg     <= '0;
      treg     <= '0;
      byte_ptr <= PTR_Z;
      tful     <= 1'b0;
    end else begin
      if (fetch_load) begin
        ireg     <= bus.dbin;
        byte_ptr <= PTR_Z;
        tful     <= 1'b0;
      end else if (data_load) begin
        case (byte_ptr)
          PTR_Z: begin
            treg[DATA_W-1:0] <= bus.dbin;
            byte_ptr         <= PTR_W;
          end
          PTR_W: begin
            treg[ADDR_W-1:DATA_W] <= bus.dbin;
            byte_ptr              <= PTR_Z;
            tful                  <= 1'b1;
          end
          default: begin
            byte_ptr <= PTR_Z;
          end
        endcase
      end
    end
  end

  // Sticky protocol error: the controller must never request an opcode and
  // an operand capture in the same cycle. Only reset clears it.
  always_ff @(posedge clk_ or posedge rst_) begin
    if (rst_) begin
      err <= 1'b0;
    end else if (wr_collide) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_unit.sv
// -----------------------------------------------------------------------------
// tb_bus_unit
//
// Self-checking bench for bus_unit: directed scenarios with literal
// expectations followed by randomized traffic (including mid-cycle reset
// pulses), all cross-checked every falling edge against a behavioural model.
// -----------------------------------------------------------------------------
module tb_bus_unit;

  logic        clk_ = 1'b0;
  logic        rst_;
  logic [15:0] dadr;
  logic [7:0]  wdat;
  logic        pcld;
  logic [15:0] pcval;
  logic [15:0] pc;
  logic [7:0]  ireg;
  logic [15:0] treg;
  logic        tful;
  logic [15:0] cur_adr;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  bus_unit_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  bus_unit #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk_    (clk_),
    .rst_    (rst_),
    .bus     (bus.slave),
    .dadr    (dadr),
    .wdat    (wdat),
    .pcld    (pcld),
    .pcval   (pcval),
    .pc      (pc),
    .ireg    (ireg),
    .treg    (treg),
    .tful    (tful),
    .cur_adr (cur_adr),
    .err     (err)
  );

  always #5 clk_ = ~clk_;

  // Behavioural model: operand bytes are tracked as a count since the last
  // opcode fetch; even counts land in Z, odd in W, and two or more means full.
  logic [15:0] m_pc   = '0;
  logic [15:0] m_cur  = '0;
  logic [7:0]  m_ireg = '0;
  logic [7:0]  m_z    = '0;
  logic [7:0]  m_w    = '0;
  int          m_cnt  = 0;
  logic        m_err  = 1'b0;

  always @(posedge clk_ or posedge rst_) begin
    if (rst_) begin
      m_pc   <= '0;
      m_cur  <= '0;
      m_ireg <= '0;
      m_z    <= '0;
      m_w    <= '0;
      m_cnt  <= 0;
      m_err  <= 1'b0;
    end else begin
      if (bus.ale) m_cur <= bus.oenb[8] ? dadr : m_pc;
      if (pcld) m_pc <= pcval;
      else if (bus.oenb[7]) m_pc <= m_pc + 16'd1;
      if (bus.oenb[5] && bus.oenb[6]) m_err <= 1'b1;
      if (bus.oenb[5] && !bus.oenb[2]) begin
        m_ireg <= bus.dbin;
        m_cnt  <= 0;
      end else if (bus.oenb[6] && !bus.oenb[5] && !bus.oenb[2]) begin
        if (m_cnt % 2 == 0) m_z <= bus.dbin;
        else m_w <= bus.dbin;
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output with the model
  task automatic checkOutput();
    logic [15:0] src;
    logic [7:0]  exp_ad;
    src    = bus.oenb[8] ? dadr : m_pc;
    exp_ad = bus.ale ? src[7:0] : (bus.oenb[2] ? wdat : m_cur[7:0]);
    checkEq("pc",      pc,      m_pc);
    checkEq("ireg",    ireg,    m_ireg);
    checkEq("treg",    treg,    {m_w, m_z});
    checkEq("tful",    tful,    (m_cnt >= 2));
    checkEq("cur_adr", cur_adr, m_cur);
    checkEq("err",     err,     m_err);
    checkEq("a_hi",    bus.a_hi, bus.ale ? src[15:8] : m_cur[15:8]);
    checkEq("ad_out",  bus.ad_out, exp_ad);
    checkEq("ah_oe",   bus.ah_oe, bus.oenb[1]);
    checkEq("ad_oe",   bus.ad_oe, bus.oenb[0] | bus.oenb[2]);
  endtask

  always @(negedge clk_) checkOutput();

  task automatic applyStimulus(input logic [8:0] o, input logic a, input logic [7:0] d,
                               input logic [15:0] da, input logic [7:0] wd,
                               input logic pl, input logic [15:0] pv);
    bus.oenb = o;
    bus.ale  = a;
    bus.dbin = d;
    dadr     = da;
    wdat     = wd;
    pcld     = pl;
    pcval    = pv;
    #1;
  endtask

  task automatic idle();
    applyStimulus(9'h000, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000);
  endtask

  task automatic step();
    @(posedge clk_);
    #2;
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    summary();
    $finish;
  end

  initial begin
    logic [8:0]  o;
    logic [15:0] pv;

    // Reset state and reset pass-through of the pin enables
    rst_ = 1'b1;
    idle();
    repeat (3) @(posedge clk_);
    #3;
    checkEq("rst_pc",      pc,      16'h0000);
    checkEq("rst_ireg",    ireg,    8'h00);
    checkEq("rst_treg",    treg,    16'h0000);
    checkEq("rst_cur_adr", cur_adr, 16'h0000);
    checkEq("rst_tful",    tful,    1'b0);
    checkEq("rst_err",     err,     1'b0);
    applyStimulus(9'h103, 1'b1, 8'h00, 16'hBEEF, 8'h00, 1'b0, 16'h0000);
    checkEq("rst_a_hi",    bus.a_hi,   8'hBE);
    checkEq("rst_ad_out",  bus.ad_out, 8'hEF);
    checkEq("rst_ah_oe",   bus.ah_oe,  1'b1);
    checkEq("rst_ad_oe",   bus.ad_oe,  1'b1);
    idle();
    rst_ = 1'b0;

    // Fetch
    applyStimulus(9'h000, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b1, 16'h1234);
    step();
    checkEq("fetch_pcld", pc, 16'h1234);
    applyStimulus(9'h003, 1'b1, 8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000);
    checkEq("fetch_a_hi",   bus.a_hi,   8'h12);
    checkEq("fetch_ad_out", bus.ad_out, 8'h34);
    step();
    checkEq("fetch_cur_adr", cur_adr, 16'h1234);
    applyStimulus(9'h020, 1'b0, 8'h3A, 16'h0000, 8'h00, 1'b0, 16'h0000);
    checkEq("fetch_a_hi_held", bus.a_hi, 8'h12);
    step();
    checkEq("fetch_ireg", ireg, 8'h3A);
    applyStimulus(9'h080, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000);
    step();
    checkEq("fetch_uppc", pc, 16'h1235);
    checkEq("model_pc",   m_pc, 16'h1235);

    // Two-byte read and wrap to Z
    applyStimulus(9'h040, 1'b0, 8'h78, 16'h0000, 8'h00, 1'b0, 16'h0000);
    step();
    checkEq("rd_z",      treg, 16'h0078);
    checkEq("rd_z_tful", tful, 1'b0);
    applyStimulus(9'h040, 1'b0, 8'h56, 16'h0000, 8'h00, 1'b0, 16'h0000);
    step();
    checkEq("rd_w",      treg, 16'h5678);
    checkEq("rd_w_tful", tful, 1'b1);
    applyStimulus(9'h040, 1'b0, 8'h9A, 16'h0000, 8'h00, 1'b0, 16'h0000);
    step();
    checkEq("rd_wrap",      treg, 16'h569A);
    checkEq("rd_wrap_tful", tful, 1'b1);
    checkEq("model_treg",   {m_w, m_z}, 16'h569A);

    // Data address and write cycle
    applyStimulus(9'h103, 1'b1, 8'h00, 16'h8000, 8'h00, 1'b0, 16'h0000);
    checkEq("wr_a_hi", bus.a_hi, 8'h80);
    step();
    checkEq("wr_cur_adr", cur_adr, 16'h8000);
    applyStimulus(9'h144, 1'b0, 8'hEE, 16'h8000, 8'hC3, 1'b0, 16'h0000);
    checkEq("wr_ad_out", bus.ad_out, 8'hC3);
    checkEq("wr_ad_oe",  bus.ad_oe,  1'b1);
    step();
    checkEq("wr_treg_kept", treg, 16'h569A);
    checkEq("wr_tful_kept", tful, 1'b1);

    // PC boundaries
    applyStimulus(9'h000, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b1, 16'hFFFF);
    step();
    applyStimulus(9'h080, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000);
    step();
    checkEq("pc_wrap", pc, 16'h0000);
    applyStimulus(9'h080, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b1, 16'h0038);
    step();
    checkEq("pc_load_prio", pc, 16'h0038);

    // Protocol error
    applyStimulus(9'h060, 1'b0, 8'h11, 16'h0000, 8'h00, 1'b0, 16'h0000);
    step();
    checkEq("err_ireg", ireg, 8'h11);
    checkEq("err_treg", treg, 16'h569A);
    checkEq("err_set",  err,  1'b1);
    idle();
    repeat (3) step();
    checkEq("err_sticky", err, 1'b1);

    // Async reset aborts a partial operand load
    applyStimulus(9'h040, 1'b0, 8'h55, 16'h0000, 8'h00, 1'b0, 16'h0000);
    step();
    checkEq("ar_z", treg, 16'h5655);
    idle();
    rst_ = 1'b1;
    #1;
    checkEq("ar_pc",   pc,   16'h0000);
    checkEq("ar_ireg", ireg, 8'h00);
    checkEq("ar_treg", treg, 16'h0000);
    checkEq("ar_err",  err,  1'b0);
    checkEq("ar_cur",  cur_adr, 16'h0000);
    rst_ = 1'b0;
    applyStimulus(9'h040, 1'b0, 8'hAB, 16'h0000, 8'h00, 1'b0, 16'h0000);
    step();
    checkEq("ar_first_z", treg, 16'h00AB);
    checkEq("ar_tful",    tful, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      o = '0;
      for (int b = 0; b < 9; b++) o[b] = ($urandom_range(0, 2) == 0);
      if (o[5] && o[6] && ($urandom_range(0, 7) != 0)) o[6] = 1'b0;
      pv = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      applyStimulus(o, 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom),
                    8'($urandom), ($urandom_range(0, 7) == 0), pv);
      if ($urandom_range(0, 39) == 0) begin
        rst_ = 1'b1;
        #1;
        rst_ = 1'b0;
      end
      step();
    end

    idle();
    step();
    summary();
    $finish;
  end

endmodule

// File: doc/bus_unit.md
BUS_UNIT -- requirements
Module: bus_unit

Interface
REQ-001 Parameters SHALL be listed one per line as name, default, meaning:
  - ADDR_W, 16, address/PC width.
  - DATA_W, 8, data bus width.
REQ-002 Ports SHALL be listed one per line as name, direction, width, meaning:
  - clk_, input, 1, clock; all state updates on rising edge.
  - rst_, input, 1, reset; asynchronous, active-high.
  - oenb, input, 9, control enables from the timing controller: bit0 ADDL, bit1 ADDH, bit2 DATA, bit3 REGR, bit4 REGW, bit5 C_WR, bit6 D_WR, bit7 UPPC, bit8 PDAT.
  - ale, input, 1, address latch enable from the timing controller.
  - dbin, input, 8, data sampled from the AD pins.
  - dadr, input, 16, data address from the register file (HL/SP/BC/DE/WZ).
  - wdat, input, 8, write data from the register file/ALU.
  - pcld, input, 1, PC load request (jump/call/ret/rst).
  - pcval, input, 16, PC load value.
  - a_hi, output, 8, address bus A15..A8.
  - ad_out, output, 8, multiplexed AD7..AD0 drive value.
  - ah_oe, output, 1, A15..A8 output enable.
  - ad_oe, output, 1, AD7..AD0 output enable.
  - pc, output, 16, program counter.
  - ireg, output, 8, instruction register.
  - treg, output, 16, temp register {W,Z}.
  - tful, output, 1, both treg bytes loaded since last fetch.
  - cur_adr, output, 16, address of the current machine cycle.
  - err, output, 1, sticky protocol error.

Function
REQ-003 Address source src SHALL be dadr when oenb[8]=1, else pc.
REQ-004 At a rising edge with ale=1, cur_adr SHALL load src.
REQ-005 a_hi SHALL equal src[15:8] while ale=1, else cur_adr[15:8].
REQ-006 ad_out SHALL equal src[7:0] while ale=1; wdat while ale=0 and oenb[2]=1; else cur_adr[7:0].
REQ-007 ah_oe SHALL equal oenb[1]; ad_oe SHALL equal oenb[0] OR oenb[2]; both are combinational with no added latency.
REQ-008 At a rising edge with pcld=1, pc SHALL load pcval; pcld has priority over UPPC.
REQ-009 At a rising edge with pcld=0 and oenb[7]=1, pc SHALL increment by 1 modulo 2^16 (0xFFFF -> 0x0000).
REQ-010 At a rising edge with oenb[5]=1 and oenb[2]=0, ireg SHALL load dbin, and the byte pointer and tful SHALL clear.
REQ-011 At a rising edge with oenb[6]=1, oenb[5]=0 and oenb[2]=0, treg SHALL load one byte:
  - pointer=0: Z (treg[7:0]) loads, then pointer becomes 1.
  - pointer=1: W (treg[15:8]) loads, then pointer becomes 0 and tful becomes 1.
REQ-012 D_WR with oenb[2]=1 (write cycle) SHALL NOT modify treg, the pointer or tful.
REQ-013 A third D_WR without an intervening C_WR SHALL wrap to Z; tful SHALL stay 1.
REQ-014 oenb[5] and oenb[6] both 1 in the same cycle SHALL set err.
  - Only ireg loads (per REQ-010); treg is unchanged.
  - err stays 1 until reset.
REQ-015 oenb[3] and oenb[4] SHALL be ignored by this block.
REQ-016 Captured values (ireg/treg/pc/cur_adr) SHALL be visible on outputs the cycle after the capturing edge.

Reset
REQ-017 rst_=1 SHALL immediately, regardless of clock, force:
  - pc=0x0000, ireg=0x00, treg=0x0000, cur_adr=0x0000.
  - pointer=0, tful=0, err=0.
REQ-018 Outputs derived from oenb/ale SHALL follow their inputs during reset.
REQ-019 Reset asserted mid-cycle SHALL abort any partial two-byte load; the first D_WR after release SHALL load Z.
REQ-020 The first edge after rst_ falls SHALL operate normally.

Verification
REQ-021 Bench SHALL cover the following directed scenarios:
  - Fetch: pc=0x1234, ale=1, oenb[0,1]=1 -> a_hi=0x12, ad_out=0x34; then C_WR with dbin=0x3A -> ireg=0x3A; UPPC -> pc=0x1235.
  - Two-byte read: D_WR with dbin=0x78, then dbin=0x56 -> treg=0x5678, tful=1; a third D_WR with 0x9A -> treg=0x569A.
  - Data address and write: PDAT=1, dadr=0x8000, ale=1 -> cur_adr=0x8000; then DATA=1, wdat=0xC3 -> ad_out=0xC3, ad_oe=1; D_WR in that cycle leaves treg unchanged.
  - PC boundaries: pc=0xFFFF with UPPC -> 0x0000; pcld=1, pcval=0x0038 together with UPPC -> pc=0x0038.
  - Protocol error: C_WR and D_WR together with dbin=0x11 -> ireg=0x11, treg unchanged, err=1 held until reset.
  - Async reset: rst_ pulsed between edges after one Z load -> all registers 0 at once; next D_WR with 0xAB -> treg=0x00AB, tful=0.
